if_fetch_unit: RTL and testbench

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

---
 rtl/if_fetch_unit_pkg.sv | 18 +
 rtl/if_fetch_unit.sv | 127 ++++++++++++
 tb/tb_if_fetch_unit.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared processor package: fetch FSM encoding, reset PC, NOP word, PC helper.
package if_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Sequential successor of a fetch address; wraps modulo 2^32 with no flag.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, zero-bubble streaming,
// a hold buffer for downstream freeze and a redirect register that lets a
// branch wait for an in-flight request to drain before refetching.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] Instruction_out,
  output logic        valid_out
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  redirect_q, redirect_d;
  logic [31:0]  hold_pc_q, hold_pc_d;
  logic [31:0]  hold_instr_q, hold_instr_d;
  logic [31:0]  pc_plus4;

  assign pc_plus4 = pc_inc(pc_q);

  // State and datapath registers; reset acts immediately, even mid-request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      redirect_q   <= 32'h0;
      hold_pc_q    <= 32'h0;
      hold_instr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
    end
  end

  // Next-state and output decode. A branch always suppresses valid_out and
  // beats freeze; an outstanding request is never abandoned (DRAIN).
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    redirect_d      = redirect_q;
    hold_pc_d       = hold_pc_q;
    hold_instr_d    = hold_instr_q;
    imem_req        = 1'b0;
    imem_addr       = pc_q;
    valid_out       = 1'b0;
    PC_out          = 32'h0;
    Instruction_out = NOP_INSTR;

    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          if (branch_taken) begin
            // Returned word is on the wrong path: drop it and refetch.
            pc_d = branch_addr;
          end else begin
            valid_out       = 1'b1;
            PC_out          = pc_plus4;
            Instruction_out = imem_rdata;
            if (freeze) begin
              // Consumer stalled: park the word; pc advances on release.
              hold_pc_d    = pc_plus4;
              hold_instr_d = imem_rdata;
              state_d      = HOLD;
            end else begin
              pc_d = pc_plus4;
            end
          end
        end else if (branch_taken) begin
          redirect_d = branch_addr;
          state_d    = DRAIN;
        end
      end

      DRAIN: begin
        // Keep the old address up until memory answers, then discard it.
        imem_req = 1'b1;
        if (branch_taken) redirect_d = branch_addr;
        if (imem_ready) begin
          pc_d    = branch_taken ? branch_addr : redirect_q;
          state_d = FETCH;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_d    = branch_addr;
          state_d = FETCH;
        end else begin
          valid_out       = 1'b1;
          PC_out          = hold_pc_q;
          Instruction_out = hold_instr_q;
          if (!freeze) begin
            pc_d    = pc_plus4;
            state_d = FETCH;
          end
        end
      end

      default: state_d = FETCH;
    endcase

    // Outputs read as idle for the whole time reset is held.
    if (rst) begin
      imem_req        = 1'b0;
      valid_out       = 1'b0;
      PC_out          = 32'h0;
      Instruction_out = NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus pushes expected (PC_out, instr)
// pairs; a negedge monitor pops and compares whenever valid_out is high.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] Instruction_out;
  logic        valid_out;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  // Memory model: word at 16 is special, everything else tagged by address.
  always_comb imem_rdata = (imem_addr == 32'd16) ? 32'hE3A0_1005
                                                 : (32'hC000_0000 | imem_addr);

  if_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_out(PC_out),
    .Instruction_out(Instruction_out), .valid_out(valid_out)
  );

  // Monitor: every presented instruction must match the head of the queue;
  // idle cycles must show the idle output values.
  always @(negedge clk) begin
    n_vec++;
    if (valid_out) begin
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: PC_out=%h instr=%h, expected no valid", PC_out, Instruction_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (PC_out !== e.pc || Instruction_out !== e.ins) begin
          n_bad++;
          $display("FAIL presented: got pc=%h instr=%h, expected pc=%h instr=%h",
                   PC_out, Instruction_out, e.pc, e.ins);
        end
      end
    end else if (PC_out !== 32'h0 || Instruction_out !== NOP) begin
      n_bad++;
      $display("FAIL idle_outputs: got pc=%h instr=%h, expected pc=0 instr=%h",
               PC_out, Instruction_out, NOP);
    end
  end

  task automatic cyc(input logic rdy, input logic frz, input logic br, input logic [31:0] ba);
    @(posedge clk);
    #1;
    imem_ready   = rdy;
    freeze       = frz;
    branch_taken = br;
    branch_addr  = ba;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    exp_t e;
    e.pc  = pc;
    e.ins = ins;
    sb.push_back(e);
  endtask

  task automatic chk_fetch(input logic [31:0] a);
    #1;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== a) begin
      n_bad++;
      $display("FAIL fetch_addr: got req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, a);
    end
  endtask

  task automatic chk_idle();
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL req_idle: got req=%b, expected 0", imem_req);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    n_vec++;
    if (imem_req !== 1'b0 || valid_out !== 1'b0 || PC_out !== 32'h0 || Instruction_out !== NOP) begin
      n_bad++;
      $display("FAIL %s: got req=%b vld=%b pc=%h instr=%h, expected 0 0 0 %h",
               tag, imem_req, valid_out, PC_out, Instruction_out, NOP);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outs("reset_state");

    // Streaming from reset: 0, 4, then a 3-cycle stall at 8
    cyc(1, 0, 0, 0); rst = 1'b0; push(32'd4, 32'hC000_0000); chk_fetch(32'd0);
    cyc(1, 0, 0, 0); push(32'd8, 32'hC000_0004); chk_fetch(32'd4);
    repeat (3) begin cyc(0, 0, 0, 0); chk_fetch(32'd8); end
    cyc(1, 0, 0, 0); push(32'd12, 32'hC000_0008); chk_fetch(32'd8);
    cyc(1, 0, 0, 0); push(32'd16, 32'hC000_000C); chk_fetch(32'd12);

    // Freeze for 4 cycles on the word at 16, then release
    cyc(1, 1, 0, 0); push(32'd20, 32'hE3A0_1005); chk_fetch(32'd16);
    repeat (3) begin cyc(1, 1, 0, 0); push(32'd20, 32'hE3A0_1005); chk_idle(); end
    cyc(1, 0, 0, 0); push(32'd20, 32'hE3A0_1005); chk_idle();
    cyc(1, 0, 0, 0); push(32'd24, 32'hC000_0014); chk_fetch(32'd20);

    // Branch while waiting at 24, re-branch in DRAIN, then drain
    cyc(0, 0, 1, 32'h100); chk_fetch(32'd24);
    cyc(0, 0, 1, 32'h200); chk_fetch(32'd24);
    cyc(1, 0, 0, 0); chk_fetch(32'd24);
    cyc(0, 0, 0, 0); chk_fetch(32'h200);
    cyc(1, 0, 0, 0); push(32'h204, 32'hC000_0200); chk_fetch(32'h200);

    // Branch with freeze while holding
    cyc(1, 1, 0, 0); push(32'h208, 32'hC000_0204); chk_fetch(32'h204);
    cyc(1, 1, 1, 32'h300); chk_idle();
    cyc(1, 0, 0, 0); push(32'h304, 32'hC000_0300); chk_fetch(32'h300);

    // Branch on a ready cycle to the top of memory, stream across the wrap
    cyc(1, 0, 1, 32'hFFFF_FFFC); chk_fetch(32'h304);
    cyc(1, 0, 0, 0); push(32'h0, 32'hFFFF_FFFC); chk_fetch(32'hFFFF_FFFC);
    cyc(1, 0, 0, 0); push(32'd4, 32'hC000_0000); chk_fetch(32'd0);

    // Reset asserted mid-DRAIN
    cyc(0, 0, 1, 32'h400); chk_fetch(32'd4);
    cyc(0, 0, 0, 0); chk_fetch(32'd4);
    rst = 1'b1;
    #1;
    chk_reset_outs("reset_in_drain");
    cyc(0, 0, 0, 0);
    #1;
    chk_reset_outs("reset_held");
    cyc(0, 0, 0, 0); rst = 1'b0; chk_fetch(32'd0);
    cyc(1, 0, 0, 0); push(32'd4, 32'hC000_0000); chk_fetch(32'd0);
    cyc(0, 0, 0, 0); chk_fetch(32'd4);

    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d expected instructions never presented, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
